// File: rtl/sm_mmio_timer_pkg.sv
// sm_mmio_timer_pkg
// Typed view of the shared timer constants: the state enum and the
// register-select / bit-position localparams used by the RTL.
// Ports: none (package).

`include "sm_timer.vh"

package sm_mmio_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = `SM_TIMER_ST_IDLE,
        ST_RUN  = `SM_TIMER_ST_RUN,
        ST_DONE = `SM_TIMER_ST_DONE
    } state_t;

    localparam logic [3:0] OFF_CTRL   = `SM_TIMER_OFF_CTRL;
    localparam logic [3:0] OFF_LOAD   = `SM_TIMER_OFF_LOAD;
    localparam logic [3:0] OFF_COUNT  = `SM_TIMER_OFF_COUNT;
    localparam logic [3:0] OFF_STATUS = `SM_TIMER_OFF_STATUS;

    // Register select is the word index, so byte lanes are ignored.
    localparam logic [1:0] SEL_CTRL   = OFF_CTRL[3:2];
    localparam logic [1:0] SEL_LOAD   = OFF_LOAD[3:2];
    localparam logic [1:0] SEL_COUNT  = OFF_COUNT[3:2];
    localparam logic [1:0] SEL_STATUS = OFF_STATUS[3:2];

    localparam int CTRL_EN        = `SM_TIMER_CTRL_EN_BIT;
    localparam int CTRL_AUTO      = `SM_TIMER_CTRL_AUTO_BIT;
    localparam int CTRL_IRQEN     = `SM_TIMER_CTRL_IRQEN_BIT;
    localparam int CTRL_PRESC_LSB = `SM_TIMER_CTRL_PRESC_LSB;
    localparam int CTRL_PRESC_MSB = `SM_TIMER_CTRL_PRESC_MSB;

    localparam int STATUS_EXP     = `SM_TIMER_STATUS_EXP_BIT;
    localparam int STATUS_ST_LSB  = `SM_TIMER_STATUS_ST_LSB;
    localparam int STATUS_ST_MSB  = `SM_TIMER_STATUS_ST_MSB;

endpackage

// File: rtl/sm_timer.vh
// sm_timer.vh
// Shared constants for the memory-mapped timer: register byte offsets
// within the 16-byte window, CTRL/STATUS bit positions and the
// state encodings reported in STATUS[2:1].
// Ports: none (header only).

`ifndef SM_TIMER_VH
`define SM_TIMER_VH

`define SM_TIMER_OFF_CTRL        4'h0
`define SM_TIMER_OFF_LOAD        4'h4
`define SM_TIMER_OFF_COUNT       4'h8
`define SM_TIMER_OFF_STATUS      4'hC

`define SM_TIMER_CTRL_EN_BIT     0
`define SM_TIMER_CTRL_AUTO_BIT   1
`define SM_TIMER_CTRL_IRQEN_BIT  2
`define SM_TIMER_CTRL_PRESC_LSB  8
`define SM_TIMER_CTRL_PRESC_MSB  15

`define SM_TIMER_STATUS_EXP_BIT  0
`define SM_TIMER_STATUS_ST_LSB   1
`define SM_TIMER_STATUS_ST_MSB   2

`define SM_TIMER_ST_IDLE         2'd0
`define SM_TIMER_ST_RUN          2'd1
`define SM_TIMER_ST_DONE         2'd2

`endif

// File: rtl/sm_timer_prescaler.sv
// sm_timer_prescaler
// Tick generator: tick is high for one clk cycle out of every presc+1
// while clr is low. clr holds the phase counter at zero, so the first
// tick after clr drops comes presc cycles later.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous reset, active-low
//   clr    in   hold counter at zero, suppress tick
//   presc  in   [7:0] divide ratio minus one
//   tick   out  one-cycle tick pulse

module sm_timer_prescaler (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic [7:0] presc,
    output logic       tick
);

    logic [7:0] cnt;

    // >= rather than == so a smaller PRESC written mid-run cannot strand
    // the counter above the terminal value.
    assign tick = !clr && (cnt >= presc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (clr || tick) begin
            cnt <= 8'd0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/sm_mmio_timer.sv
// sm_mmio_timer
// Memory-mapped down-counting timer on the CPU data-memory bus.
// Register window (16 bytes at BASE_ADDR):
//   0x0 CTRL   bit0 EN, bit1 AUTO, bit2 IRQ_EN, [15:8] PRESC
//   0x4 LOAD
//   0x8 COUNT
//   0xC STATUS bit0 EXP (write 1 to clear), [2:1] state
// Reads are combinational; writes land on the clk edge with hit & dmWe.
// Build option: define SM_TIMER_PRESCALER_EN to divide the tick rate by
// PRESC+1; otherwise the timer ticks every cycle and PRESC reads 0.
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous reset, active-low
//   dmAddr   in   [31:0] byte address
//   dmWe     in   write enable
//   dmWData  in   [31:0] write data
//   rdata    out  [31:0] read data, 0 outside the window
//   hit      out  address inside the window
//   irq      out  EXP & IRQ_EN

`include "sm_timer.vh"

module sm_mmio_timer
    import sm_mmio_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dmAddr,
    input  logic        dmWe,
    input  logic [31:0] dmWData,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        irq
);

    logic [1:0]  reg_sel;
    logic        wr_ctrl;
    logic        wr_load;
    logic        wr_count;
    logic        wr_status;
    logic        ctrl_en;
    logic        ctrl_auto;
    logic        ctrl_irq_en;
    logic [7:0]  presc_rd;
    logic [31:0] load_q;
    logic [31:0] count_q;
    logic        exp_q;
    state_t      state;
    logic        tick;
    logic        ctrl_stop;
    logic        ctrl_start;
    logic        run_tick;
    logic        expire;
    logic        unused_addr_lsbs;

    assign hit              = (dmAddr[31:4] == BASE_ADDR[31:4]);
    assign reg_sel          = dmAddr[3:2];
    assign unused_addr_lsbs = ^dmAddr[1:0];

    assign wr_ctrl   = hit && dmWe && (reg_sel == SEL_CTRL);
    assign wr_load   = hit && dmWe && (reg_sel == SEL_LOAD);
    assign wr_count  = hit && dmWe && (reg_sel == SEL_COUNT);
    assign wr_status = hit && dmWe && (reg_sel == SEL_STATUS);

`ifdef SM_TIMER_PRESCALER_EN
    logic [7:0] ctrl_presc;
    logic       presc_clr;

    // Holding the prescaler clear outside RUN restarts its phase on
    // every entry into RUN.
    assign presc_clr = (state != ST_RUN);
    assign presc_rd  = ctrl_presc;

    sm_timer_prescaler u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (presc_clr),
        .presc (ctrl_presc),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_presc <= 8'd0;
        end else if (wr_ctrl) begin
            ctrl_presc <= dmWData[CTRL_PRESC_MSB:CTRL_PRESC_LSB];
        end
    end
`else
    assign tick     = (state == ST_RUN);
    assign presc_rd = 8'd0;
`endif

    // A CTRL write with EN=0 wins over a same-cycle tick; EN=1 only
    // (re)starts the count when not already running.
    assign ctrl_stop  = wr_ctrl && !dmWData[CTRL_EN];
    assign ctrl_start = wr_ctrl && dmWData[CTRL_EN] && (state != ST_RUN);
    assign run_tick   = (state == ST_RUN) && tick && !ctrl_stop;
    assign expire     = run_tick && (count_q == 32'd0);

    assign irq = exp_q & ctrl_irq_en;

    // Later assignments in this block deliberately override earlier ones:
    // expiry clears EN after a CTRL write, and a COUNT write overrides
    // any reload or decrement on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ctrl_en     <= 1'b0;
            ctrl_auto   <= 1'b0;
            ctrl_irq_en <= 1'b0;
            load_q      <= 32'd0;
            count_q     <= 32'd0;
            exp_q       <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en     <= dmWData[CTRL_EN];
                ctrl_auto   <= dmWData[CTRL_AUTO];
                ctrl_irq_en <= dmWData[CTRL_IRQEN];
            end
            if (wr_load) begin
                load_q <= dmWData;
            end

            if (ctrl_stop) begin
                state <= ST_IDLE;
            end else if (ctrl_start) begin
                state   <= ST_RUN;
                count_q <= load_q;
            end else if (run_tick) begin
                if (count_q != 32'd0) begin
                    count_q <= count_q - 32'd1;
                end else if (ctrl_auto) begin
                    count_q <= load_q;
                end else begin
                    state   <= ST_DONE;
                    ctrl_en <= 1'b0;
                end
            end

            if (wr_count) begin
                count_q <= dmWData;
            end

            if (expire) begin
                exp_q <= 1'b1;
            end else if (wr_status && dmWData[STATUS_EXP]) begin
                exp_q <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (hit) begin
            case (reg_sel)
                SEL_CTRL: begin
                    rdata[CTRL_EN]                       = ctrl_en;
                    rdata[CTRL_AUTO]                     = ctrl_auto;
                    rdata[CTRL_IRQEN]                    = ctrl_irq_en;
                    rdata[CTRL_PRESC_MSB:CTRL_PRESC_LSB] = presc_rd;
                end
                SEL_LOAD:  rdata = load_q;
                SEL_COUNT: rdata = count_q;
                default: begin
                    rdata[STATUS_EXP]                  = exp_q;
                    rdata[STATUS_ST_MSB:STATUS_ST_LSB] = state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm_mmio_timer.sv
// tb_sm_mmio_timer
// Directed bench for sm_mmio_timer with an abstract register-level model
// that is stepped every clock and compared against hit/rdata/irq on every
// cycle, plus literal register readbacks at the interesting points.
// Honours SM_TIMER_PRESCALER_EN the same way as the design.

module tb_sm_mmio_timer;

    localparam logic [31:0] BASE = 32'h0000_7F00;
`ifdef SM_TIMER_PRESCALER_EN
    localparam bit PRESC_ON = 1'b1;
`else
    localparam bit PRESC_ON = 1'b0;
`endif
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic        clk;
    logic        rst_n;
    logic [31:0] dmAddr;
    logic        dmWe;
    logic [31:0] dmWData;
    logic [31:0] rdata;
    logic        hit;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // Model state: register contents as software would see them.
    bit          mEn, mAuto, mIrqEn, mExp;
    logic [7:0]  mPresc;
    logic [31:0] mLoad, mCount;
    int          mState;
    int          mRunCyc;

    sm_mmio_timer #(.BASE_ADDR(BASE)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .dmAddr  (dmAddr),
        .dmWe    (dmWe),
        .dmWData (dmWData),
        .rdata   (rdata),
        .hit     (hit),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    function automatic bit modelHit(input logic [31:0] a);
        return a[31:4] == BASE[31:4];
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] a);
        logic [1:0] st;
        st = mState[1:0];
        if (!modelHit(a)) return 32'd0;
        case (a[3:2])
            2'd0:    return {16'd0, mPresc, 5'd0, mIrqEn, mAuto, mEn};
            2'd1:    return mLoad;
            2'd2:    return mCount;
            default: return {29'd0, st, mExp};
        endcase
    endfunction

    task automatic modelReset();
        mEn = 0; mAuto = 0; mIrqEn = 0; mExp = 0;
        mPresc = 8'd0; mLoad = 32'd0; mCount = 32'd0;
        mState = M_IDLE; mRunCyc = 0;
    endtask

    // One clock edge of the abstract timer.
    task automatic modelStep();
        bit          w, stop, start, tk, expNow, oldAuto;
        logic [1:0]  sel;
        logic [31:0] d, oldLoad;
        w = dmWe && modelHit(dmAddr);
        sel = dmAddr[3:2];
        d = dmWData;
        oldAuto = mAuto;
        oldLoad = mLoad;
        stop  = w && sel == 2'd0 && !d[0];
        start = w && sel == 2'd0 && d[0] && mState != M_RUN;
        tk = 0;
        expNow = 0;
        if (mState == M_RUN) begin
            // A tick on every (PRESC+1)-th cycle since entering RUN.
            tk = ((mRunCyc + 1) % (int'(mPresc) + 1)) == 0;
            mRunCyc++;
        end
        if (w && sel == 2'd0) begin
            mEn = d[0]; mAuto = d[1]; mIrqEn = d[2];
            mPresc = PRESC_ON ? d[15:8] : 8'd0;
        end
        if (w && sel == 2'd1) mLoad = d;
        if (stop) begin
            mState = M_IDLE;
        end else if (start) begin
            mState = M_RUN; mCount = oldLoad; mRunCyc = 0;
        end else if (tk) begin
            if (mCount > 0) begin
                mCount = mCount - 1;
            end else begin
                expNow = 1;
                if (oldAuto) mCount = oldLoad;
                else begin mState = M_DONE; mEn = 0; end
            end
        end
        if (w && sel == 2'd2) mCount = d;
        if (expNow) mExp = 1;
        else if (w && sel == 2'd3 && d[0]) mExp = 0;
    endtask

    always @(posedge clk) begin
        if (!rst_n) modelReset();
        else modelStep();
    end

    always @(negedge rst_n) modelReset();

    task automatic checkOutput(input string name, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Every cycle, shortly after the inputs settle, compare against the model.
    always begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            checkOutput("cmp_hit", {31'd0, hit}, {31'd0, modelHit(dmAddr)});
            checkOutput("cmp_rdata", rdata, modelRead(dmAddr));
            checkOutput("cmp_irq", {31'd0, irq}, {31'd0, mExp & mIrqEn});
        end
    end

    // Drive one write for a single edge; returns on the following negedge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
        dmAddr = a; dmWe = 1'b1; dmWData = d;
        @(negedge clk);
        dmWe = 1'b0; dmWData = 32'd0;
    endtask

    task automatic checkReg(input string name, input logic [31:0] a,
                            input logic [31:0] exp);
        dmAddr = a;
        #2;
        checkOutput(name, rdata, exp);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; dmAddr = BASE; dmWe = 1'b0; dmWData = 32'd0;
        modelReset();
        $display("[TB] start, prescaler build = %0d", PRESC_ON);

        // Reset values visible through the window while held in reset.
        waitCycles(2);
        checkReg("rst_ctrl", BASE + 32'h0, 32'h0);
        checkReg("rst_count", BASE + 32'h8, 32'h0);
        checkReg("rst_status", BASE + 32'hC, 32'h0);
        checkOutput("rst_hit", {31'd0, hit}, 32'd1);
        checkOutput("rst_irq", {31'd0, irq}, 32'd0);
        #1 rst_n = 1'b1;
        waitCycles(1);

        // One-shot: LOAD=3, CTRL=EN|IRQ_EN, expires on the 4th tick.
        applyStimulus(BASE + 32'h4, 32'd3);
        applyStimulus(BASE + 32'h0, 32'h5);
        checkReg("os_count0", BASE + 32'h8, 32'd3);
        waitCycles(3);
        checkReg("os_count3", BASE + 32'h8, 32'd0);
        checkReg("os_status_pre", BASE + 32'hC, 32'h2);
        checkOutput("os_irq_pre", {31'd0, irq}, 32'd0);
        waitCycles(1);
        checkReg("os_status", BASE + 32'hC, 32'h5);
        checkOutput("os_irq", {31'd0, irq}, 32'd1);
        checkReg("os_ctrl", BASE + 32'h0, 32'h4);
        checkReg("os_count", BASE + 32'h8, 32'd0);
        waitCycles(2);
        checkReg("os_nowrap", BASE + 32'h8, 32'd0);
        applyStimulus(BASE + 32'hC, 32'h1);
        checkReg("os_clr", BASE + 32'hC, 32'h4);

        // Auto-reload: LOAD=2, CTRL=EN|AUTO -> 2,1,0,2 with EXP every 3 ticks.
        applyStimulus(BASE + 32'h4, 32'd2);
        applyStimulus(BASE + 32'h0, 32'h3);
        checkReg("ar_count0", BASE + 32'h8, 32'd2);
        waitCycles(1);
        checkReg("ar_count1", BASE + 32'h8, 32'd1);
        waitCycles(1);
        checkReg("ar_count2", BASE + 32'h8, 32'd0);
        checkReg("ar_status2", BASE + 32'hC, 32'h2);
        waitCycles(1);
        checkReg("ar_count3", BASE + 32'h8, 32'd2);
        checkReg("ar_status3", BASE + 32'hC, 32'h3);

        // EN=1 while running only updates fields: no reload.
        applyStimulus(BASE + 32'h0, 32'h7);
        checkReg("upd_count", BASE + 32'h8, 32'd1);
        checkReg("upd_ctrl", BASE + 32'h0, 32'h7);
        checkOutput("upd_irq", {31'd0, irq}, 32'd1);

        // Clear collision: set wins on the expiry edge.
        applyStimulus(BASE + 32'hC, 32'h1);
        checkReg("cc_clr_status", BASE + 32'hC, 32'h2);
        checkOutput("cc_clr_irq", {31'd0, irq}, 32'd0);
        applyStimulus(BASE + 32'hC, 32'h1);
        checkReg("cc_hit_status", BASE + 32'hC, 32'h3);
        checkOutput("cc_hit_irq", {31'd0, irq}, 32'd1);
        checkReg("cc_hit_count", BASE + 32'h8, 32'd2);
        applyStimulus(BASE + 32'hC, 32'h1);
        checkReg("cc_clr2_status", BASE + 32'hC, 32'h2);
        checkOutput("cc_clr2_irq", {31'd0, irq}, 32'd0);

        // Window decode, then stop with COUNT held.
        checkReg("win_count", 32'h0000_7F08, 32'd1);
        checkReg("win_bytelane", 32'h0000_7F0B, 32'd1);
        checkReg("win_outside", 32'h0000_7F10, 32'd0);
        checkOutput("win_outside_hit", {31'd0, hit}, 32'd0);
        applyStimulus(BASE + 32'h0, 32'h0);
        checkReg("stop_count", BASE + 32'h8, 32'd1);
        checkReg("stop_status", BASE + 32'hC, 32'h0);
        applyStimulus(32'h0000_7E04, 32'h55);
        checkOutput("miss_hit", {31'd0, hit}, 32'd0);
        checkReg("miss_load", BASE + 32'h4, 32'd2);

`ifdef SM_TIMER_PRESCALER_EN
        // PRESC=3, LOAD=1: ticks every 4 cycles, expiry on the 8th edge.
        applyStimulus(BASE + 32'h4, 32'd1);
        applyStimulus(BASE + 32'h0, 32'h0000_0301);
        checkReg("ps_ctrl", BASE + 32'h0, 32'h0000_0301);
        waitCycles(7);
        checkReg("ps_status7", BASE + 32'hC, 32'h2);
        checkReg("ps_count7", BASE + 32'h8, 32'd0);
        waitCycles(1);
        checkReg("ps_status8", BASE + 32'hC, 32'h5);
        checkReg("ps_ctrl8", BASE + 32'h0, 32'h0000_0300);
        applyStimulus(BASE + 32'hC, 32'h1);
        checkReg("ps_clr", BASE + 32'hC, 32'h4);
`else
        // Without the prescaler, PRESC bits are not stored.
        applyStimulus(BASE + 32'h0, 32'h0000_0301);
        checkReg("np_ctrl", BASE + 32'h0, 32'h0000_0001);
        checkReg("np_status", BASE + 32'hC, 32'h2);
        checkReg("np_count", BASE + 32'h8, 32'd2);
        applyStimulus(BASE + 32'h0, 32'h0);
        checkReg("np_stop", BASE + 32'hC, 32'h0);
`endif

        // LOAD=0 with AUTO expires on every tick; COUNT write overrides reload.
        applyStimulus(BASE + 32'h4, 32'd0);
        applyStimulus(BASE + 32'h0, 32'h3);
        checkReg("z_status0", BASE + 32'hC, 32'h2);
        waitCycles(1);
        checkReg("z_status1", BASE + 32'hC, 32'h3);
        checkReg("z_count1", BASE + 32'h8, 32'd0);
        applyStimulus(BASE + 32'h8, 32'd4);
        checkReg("z_cwrite", BASE + 32'h8, 32'd4);
        applyStimulus(BASE + 32'h0, 32'h0);
        checkReg("z_held", BASE + 32'h8, 32'd4);
        checkReg("z_idle", BASE + 32'hC, 32'h1);
        applyStimulus(BASE + 32'hC, 32'h1);
        checkReg("z_clr", BASE + 32'hC, 32'h0);

        // Reset pulse between edges while running with COUNT=5.
        applyStimulus(BASE + 32'h4, 32'd5);
        applyStimulus(BASE + 32'h0, 32'h5);
        checkReg("rr_count", BASE + 32'h8, 32'd5);
        checkReg("rr_status", BASE + 32'hC, 32'h2);
        #3 rst_n = 1'b0;
        checkReg("rr_ctrl0", BASE + 32'h0, 32'h0);
        checkReg("rr_load0", BASE + 32'h4, 32'h0);
        checkReg("rr_count0", BASE + 32'h8, 32'h0);
        checkReg("rr_status0", BASE + 32'hC, 32'h0);
        checkOutput("rr_irq0", {31'd0, irq}, 32'd0);
        #2 rst_n = 1'b1;
        waitCycles(8);
        checkReg("rr_after_status", BASE + 32'hC, 32'h0);
        checkReg("rr_after_count", BASE + 32'h8, 32'h0);
        checkOutput("rr_after_irq", {31'd0, irq}, 32'd0);

        waitCycles(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
